// File: rtl/gpio_apb_pkg.sv
// ----------------------------------------------------------------------------
// gpio_apb_pkg : APB initiator state encoding and GPIO register offset map.
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package gpio_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   localparam logic [7:0] GPIO_IN_OFS    = 8'h00;
   localparam logic [7:0] GPIO_OUT_OFS   = 8'h04;
   localparam logic [7:0] GPIO_OE_OFS    = 8'h08;
   localparam logic [7:0] GPIO_INTE_OFS  = 8'h0C;
   localparam logic [7:0] GPIO_PTRIG_OFS = 8'h10;
   localparam logic [7:0] GPIO_AUX_OFS   = 8'h14;
   localparam logic [7:0] GPIO_CTRL_OFS  = 8'h18;
   localparam logic [7:0] GPIO_INTS_OFS  = 8'h1C;
   localparam logic [7:0] GPIO_ECLK_OFS  = 8'h20;
   localparam logic [7:0] GPIO_NEC_OFS   = 8'h24;

   function automatic logic addr_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
// ----------------------------------------------------------------------------
// apb_timeout_ctr : 8-bit ACCESS wait-state counter with expiry compare.
// Revision        : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module apb_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_expired
);

   localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = 8'd0;
      end else if (i_inc) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expires on the stalled cycle that would bring the count up to LIMIT.
   assign o_expired = i_inc && (cnt_q == LIMIT_M1);

endmodule

`default_nettype wire

// File: rtl/apb_gpio_master.sv
// ----------------------------------------------------------------------------
// apb_gpio_master : valid/ready command to single-beat APB initiator.
// Optional macro  : APB_TIMEOUT_EN enables the ACCESS wait-state abort.
// Revision        : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module apb_gpio_master
   import gpio_apb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_chk
         $error("apb_gpio_master: TIMEOUT_CYCLES must be in 1..255");
      end
   endgenerate

   apb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
   apb_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .i_clear   (state_q != ST_ACCESS),
      .i_inc     ((state_q == ST_ACCESS) && !pready),
      .o_expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               // Misaligned commands are answered locally, no bus cycle.
               if (!addr_aligned(cmd_addr[1:0])) begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A completing pready takes priority over a same-cycle expiry.
            if (pready) begin
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               rsp_err_d   = pslverr;
               state_d     = ST_RESP;
            end else if (timeout_hit) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Handshake and bus strobes decode straight from state so reset clears them at once.
   assign cmd_ready = (state_q == ST_IDLE);
   assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign penable   = (state_q == ST_ACCESS);
   assign rsp_valid = (state_q == ST_RESP);
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_gpio_master.sv
// ----------------------------------------------------------------------------
// tb_apb_gpio_master : scoreboard bench with APB slave model for apb_gpio_master.
// Revision           : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_apb_gpio_master;
   import gpio_apb_pkg::*;

`ifdef APB_TIMEOUT_EN
   localparam int TB_TO = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TB_TO = 16;
   localparam bit TO_EN = 1'b0;
`endif
   localparam int MAXW = TO_EN ? TB_TO - 1 : 5;

   logic        sys_clk, sys_rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;

   apb_gpio_master #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TB_TO)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          waits;
      logic        err;
   } plan_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   plan_t       plan_q[$];
   exp_t        exp_q[$];
   logic [31:0] model_mem[64];
   logic [31:0] slave_mem[64];
   int          checks = 0;
   int          errors = 0;
   int          rr_mode = 0;   // 0: rsp_ready high, 1: random, 2: held low

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // APB slave: follows the per-command plan queued by the issuer
   initial begin
      plan_t cur;
      int    wcnt;
      int    idx;
      bit    have;
      have = 1'b0; wcnt = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      forever begin
         @(negedge sys_clk);
         pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
         if (!sys_rst && psel) begin
            if (!penable) begin
               checks++;
               if (plan_q.size() == 0) begin
                  errors++; have = 1'b0;
                  $display("FAIL unexpected_psel: psel=1 paddr=%h, expected no bus cycle", paddr);
               end else begin
                  cur = plan_q.pop_front(); have = 1'b1; wcnt = 0;
                  chk("setup_paddr", paddr, cur.addr);
                  chk("setup_pwrite", 32'(pwrite), 32'(cur.wr));
                  if (cur.wr) chk("setup_pwdata", pwdata, cur.data);
               end
            end else begin
               checks++;
               if (!have) begin
                  errors++;
                  $display("FAIL stray_access: penable=1 got, expected 0 outside a planned transfer");
               end else begin
                  chk("access_paddr", paddr, cur.addr);
                  chk("access_pwrite", 32'(pwrite), 32'(cur.wr));
                  if (cur.wr) chk("access_pwdata", pwdata, cur.data);
                  if (wcnt == cur.waits) begin
                     pready = 1'b1; pslverr = cur.err; idx = int'(cur.addr[7:2]);
                     if (!cur.wr) prdata = slave_mem[idx];
                     else if (!cur.err) slave_mem[idx] = pwdata;
                     have = 1'b0;
                  end else begin
                     wcnt++;
                  end
               end
            end
         end
      end
   end

   // Response monitor: drives rsp_ready and pops the scoreboard on each handshake
   initial begin
      exp_t        e;
      logic [31:0] hold_d;
      logic        hold_e;
      bit          holding;
      holding = 1'b0; hold_d = '0; hold_e = 1'b0;
      rsp_ready = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            rsp_ready = 1'b0; holding = 1'b0;
         end else begin
            if (holding) begin
               chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
               if (rsp_valid) begin
                  chk("hold_rdata", rsp_rdata, hold_d);
                  chk("hold_err", 32'(rsp_err), 32'(hold_e));
               end
            end
            case (rr_mode)
               0:       rsp_ready = 1'b1;
               1:       rsp_ready = 1'($urandom_range(0, 1));
               default: rsp_ready = 1'b0;
            endcase
            holding = 1'b0;
            if (rsp_valid) begin
               chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
               if (rsp_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h, expected no response", rsp_rdata);
                  end else begin
                     e = exp_q.pop_front();
                     chk("rsp_rdata", rsp_rdata, e.rdata);
                     chk("rsp_err", 32'(rsp_err), 32'(e.err));
                  end
               end else begin
                  holding = 1'b1; hold_d = rsp_rdata; hold_e = rsp_err;
               end
            end
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic err);
      int    g;
      int    idx;
      exp_t  e;
      plan_t p;
      g = 0;
      while (!cmd_ready) begin
         @(negedge sys_clk);
         g++;
         if (g > 300) begin
            checks++; errors++;
            $display("FAIL issue_wait: cmd_ready=%b, expected 1 within 300 cycles", cmd_ready);
            return;
         end
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      idx = int'(a[7:2]);
      if (a[1:0] != 2'b00) begin
         e.err = 1'b1; e.rdata = '0;
      end else begin
         p.wr = wr; p.addr = a; p.data = d; p.waits = waits; p.err = err;
         plan_q.push_back(p);
         if (TO_EN && waits >= TB_TO) begin
            e.err = 1'b1; e.rdata = '0;
         end else begin
            e.err   = err;
            e.rdata = wr ? 32'h0 : model_mem[idx];
            if (wr && !err) model_mem[idx] = d;
         end
      end
      exp_q.push_back(e);
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
   endtask

   // Cycle indices are counted from the accept edge (cycle 1 = first cycle after it)
   task automatic trace(output int fp, output int fe, output int fr, output int rlen);
      fp = 0; fe = 0; fr = 0; rlen = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge sys_clk);
         if (psel && fp == 0) fp = k;
         if (penable && fe == 0) fe = k;
         if (rsp_valid) begin
            if (fr == 0) fr = k;
            rlen++;
         end else if (fr != 0) begin
            break;
         end
      end
   endtask

   initial begin
      int          fp, fe, fr, rlen, g;
      logic [31:0] a;
      logic [31:0] offs[10];
      offs = '{32'(GPIO_IN_OFS), 32'(GPIO_OUT_OFS), 32'(GPIO_OE_OFS), 32'(GPIO_INTE_OFS),
               32'(GPIO_PTRIG_OFS), 32'(GPIO_AUX_OFS), 32'(GPIO_CTRL_OFS), 32'(GPIO_INTS_OFS),
               32'(GPIO_ECLK_OFS), 32'(GPIO_NEC_OFS)};
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = '0; slave_mem[i] = '0;
      end
      model_mem[7] = 32'hDEAD_BEEF; slave_mem[7] = 32'hDEAD_BEEF;
      sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;

      repeat (3) @(negedge sys_clk);
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite", 32'(pwrite), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      @(negedge sys_clk);

      // Zero-wait write: psel 1, penable 2, response 3, ready again at 4
      issue(1'b1, 32'(GPIO_OUT_OFS), 32'hA5A5_5A5A, 0, 1'b0);
      trace(fp, fe, fr, rlen);
      chk("wr_psel_cycle", 32'(fp), 32'd1);
      chk("wr_penable_cycle", 32'(fe), 32'd2);
      chk("wr_rsp_cycle", 32'(fr), 32'd3);
      chk("wr_rsp_len", 32'(rlen), 32'd1);
      chk("wr_next_ready", 32'(cmd_ready), 32'd1);
      chk("out_pad", slave_mem[1], 32'hA5A5_5A5A);

      issue(1'b1, 32'(GPIO_OE_OFS), 32'h0000_FFFF, 0, 1'b0);
      trace(fp, fe, fr, rlen);
      issue(1'b0, 32'(GPIO_OE_OFS), 32'h0, 0, 1'b0);
      trace(fp, fe, fr, rlen);

      // Three wait states stretch ACCESS to four cycles
      issue(1'b0, 32'(GPIO_IN_OFS), 32'h0, 3, 1'b0);
      trace(fp, fe, fr, rlen);
      chk("wait_psel_cycle", 32'(fp), 32'd1);
      chk("wait_penable_cycle", 32'(fe), 32'd2);
      chk("wait_rsp_cycle", 32'(fr), 32'd6);

      issue(1'b0, 32'(GPIO_INTS_OFS), 32'h0, 0, 1'b1);
      trace(fp, fe, fr, rlen);

      issue(1'b0, 32'h0000_0006, 32'h0, 0, 1'b0);
      trace(fp, fe, fr, rlen);
      chk("misalign_psel", 32'(fp), 32'd0);
      chk("misalign_rsp_cycle", 32'(fr), 32'd1);

      // Response backpressure: held response, new command ignored
      rr_mode = 2;
      issue(1'b0, 32'(GPIO_OUT_OFS), 32'h0, 0, 1'b0);
      g = 0;
      while (!rsp_valid && g < 50) begin
         @(negedge sys_clk); g++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("bp_rdata", rsp_rdata, 32'hA5A5_5A5A);
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'(GPIO_AUX_OFS); cmd_wdata = $urandom;
         @(negedge sys_clk);
      end
      cmd_valid = 1'b0;
      rr_mode = 0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      chk("bp_release_ready", 32'(cmd_ready), 32'd1);

      // Asynchronous reset during ACCESS drops the strobes at once
      issue(1'b0, 32'(GPIO_AUX_OFS), 32'h0, 1000, 1'b0);
      g = 0;
      while (!penable && g < 20) begin
         @(negedge sys_clk); g++;
      end
      chk("pre_rst_penable", 32'(penable), 32'd1);
      #2 sys_rst = 1'b1;
      #1;
      chk("midrst_psel", 32'(psel), 32'd0);
      chk("midrst_penable", 32'(penable), 32'd0);
      exp_q.delete();
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      end

`ifdef APB_TIMEOUT_EN
      issue(1'b0, 32'(GPIO_NEC_OFS), 32'h0, 1000, 1'b0);
      trace(fp, fe, fr, rlen);
      chk("to_penable_cycle", 32'(fe), 32'd2);
      chk("to_rsp_cycle", 32'(fr), 32'(2 + TB_TO));
      issue(1'b0, 32'(GPIO_ECLK_OFS), 32'h0, TB_TO - 1, 1'b0);
      trace(fp, fe, fr, rlen);
      chk("to_edge_rsp_cycle", 32'(fr), 32'(2 + TB_TO));
`endif

      // Randomized traffic with random wait states, errors and backpressure
      rr_mode = 1;
      for (int n = 0; n < 80; n++) begin
         a = offs[$urandom_range(0, 9)];
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         issue(1'($urandom), a, $urandom, int'($urandom_range(0, MAXW)),
               ($urandom_range(0, 5) == 0));
         repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      end

      g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         @(negedge sys_clk); g++;
      end
      chk("drain_rsp_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_plan_queue", 32'(plan_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
